// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small shift-register FIFO of fetched entries; head always sits in slot 0 so
// the head outputs come straight from flops. Empty slots are held at zero.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     din,
  output fetch_entry_t     head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned IDX_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_entry_t      mem [QDEPTH];
  logic [QDEPTH-1:0] vld;
  logic [IDX_W-1:0]  wr_idx;

  // With a simultaneous pop, the tail moves down one slot before the write.
  assign wr_idx = pop ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      vld   <= '0;
      count <= '0;
    end else if (flush) begin
      // A flush may carry one replacement entry (used for fault reporting).
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      vld   <= '0;
      count <= '0;
      if (push) begin
        mem[0] <= din;
        vld[0] <= 1'b1;
        count  <= CNT_W'(1);
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
          vld[i] <= vld[i+1];
        end
        mem[QDEPTH-1] <= '0;
        vld[QDEPTH-1] <= 1'b0;
      end
      if (push) begin
        mem[wr_idx] <= din;
        vld[wr_idx] <= 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head       = mem[0];
  assign head_valid = vld[0];

  // Slot reservation in the fetch FSM must make overflow unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count == CNT_W'(QDEPTH))));

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one request in flight and queues
// returned instructions for decode. FETCH_ALIGN_CHECK_EN adds misaligned-redirect faults.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                CLK,
  input  logic                resetl,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_W-1:0]     imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [INSTR_W-1:0]  out_instr,
  output logic                out_fault
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  fetch_state_t     state, state_n;
  logic [PC_W-1:0]  fetch_pc, fetch_pc_n;
  logic [PC_W-1:0]  req_pc, req_pc_n;
  logic             drop, drop_n;
  logic             req_valid_q;

  logic             q_flush, q_push, q_pop;
  fetch_entry_t     q_din, q_head;
  logic             q_head_valid;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] cnt_after;

  logic [PC_W-1:0]  rdr_pc;
  logic             misalign;
  logic             hs;
  logic             in_flight;

`ifdef FETCH_ALIGN_CHECK_EN
  assign rdr_pc    = redirect_pc;
  assign misalign  = |redirect_pc[1:0];
  assign out_fault = q_head.fault;
`else
  assign rdr_pc    = {redirect_pc[PC_W-1:2], 2'b00};
  assign misalign  = 1'b0;
  assign out_fault = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], q_head.fault};
`endif

  assign hs = (state == REQ) && imem_req_ready;

  // A response is still owed to us after this cycle.
  assign in_flight = hs ||
                     (((state == WAIT) || ((state == HALT) && drop)) && !imem_rsp_valid);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      drop        <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      req_pc      <= req_pc_n;
      drop        <= drop_n;
      req_valid_q <= (state_n == REQ);
    end
  end

  // Next-state, PC update and queue control; redirect overrides everything.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_pc_n   = req_pc;
    drop_n     = drop;
    q_flush    = 1'b0;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    q_din      = '0;
    cnt_after  = q_count;

    if (redirect_valid) begin
      q_flush    = 1'b1;
      fetch_pc_n = rdr_pc;
      drop_n     = in_flight;
      if (misalign) begin
        q_push       = 1'b1;
        q_din.pc     = rdr_pc;
        q_din.fault  = 1'b1;
        state_n      = HALT;
      end else begin
        state_n = in_flight ? WAIT : IDLE;
      end
    end else begin
      q_pop = q_head_valid && out_ready;
      case (state)
        IDLE: begin
          if (q_count < CNT_W'(QDEPTH)) state_n = REQ;
        end
        REQ: begin
          if (imem_req_ready) begin
            req_pc_n   = fetch_pc;
            fetch_pc_n = fetch_pc + PC_INC;
            state_n    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_n = 1'b0;
            end else begin
              q_push      = 1'b1;
              q_din.pc    = req_pc;
              q_din.instr = imem_rsp_data;
            end
            cnt_after = q_count + CNT_W'(q_push) - CNT_W'(q_pop);
            state_n   = (cnt_after < CNT_W'(QDEPTH)) ? REQ : IDLE;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        HALT: begin
          if (imem_rsp_valid) drop_n = 1'b0;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (CLK),
    .rst_n      (resetl),
    .flush      (q_flush),
    .push       (q_push),
    .pop        (q_pop),
    .din        (q_din),
    .head       (q_head),
    .head_valid (q_head_valid),
    .count      (q_count)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc;
  assign out_valid      = q_head_valid;
  assign out_pc         = q_head.pc;
  assign out_instr      = q_head.instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a variable-latency memory model;
// the misaligned-redirect scenario depends on FETCH_ALIGN_CHECK_EN.
module tb_pc_fetch_unit;

  localparam logic [63:0] RPC = 64'h1000;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_unit #(.RESET_PC(RPC), .QDEPTH(2)) dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] f(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // Memory model: a handshake seen at a falling edge completes on the next
  // rising edge; the response is raised lat falling edges later.
  int          lat = 1;
  bit          pend;
  int          cnt;
  logic [63:0] pend_addr;
  logic [63:0] req_log [64];
  int          req_n;

  always @(negedge CLK) begin
    if (!resetl) begin
      pend = 1'b0;
      cnt = 0;
      imem_rsp_valid = 1'b0;
      req_n = 0;
    end else begin
      if (imem_rsp_valid) imem_rsp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = f(pend_addr);
          pend = 1'b0;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend = 1'b1;
        cnt = lat;
        pend_addr = imem_req_addr;
        if (req_n < 64) req_log[req_n] = imem_req_addr;
        req_n++;
      end
    end
  end

  // Decode-side monitor: logs every entry that will be popped.
  logic [63:0] opc_log   [64];
  logic [31:0] oins_log  [64];
  logic        oflt_log  [64];
  int          out_n;

  always @(negedge CLK) begin
    if (!resetl) begin
      out_n = 0;
    end else if (out_valid && out_ready && !redirect_valid) begin
      if (out_n < 64) begin
        opc_log[out_n]  = out_pc;
        oins_log[out_n] = out_instr;
        oflt_log[out_n] = out_fault;
      end
      out_n++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic rv, input logic [63:0] rpc);
    resetl = 1'b0;
    redirect_valid = rv;
    redirect_pc = rpc;
    repeat (2) @(posedge CLK);
    #1;
    resetl = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (out_n < n && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (out_n < n) begin
      n_fail++;
      $display("FAIL wait_out: got %0d outputs, need %0d", out_n, n);
    end
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_tests += 6;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_pc !== 64'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
    if (out_fault !== 1'b0) begin n_fail++; $display("FAIL rst_out_fault: got %b want 0", out_fault); end
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    if (imem_req_addr !== RPC) begin n_fail++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RPC); end
  endtask

  task automatic test_sequential();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    do_reset(1'b0, '0);
    wait_out(3, 100);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] e;
      e = RPC + 64'(4 * i);
      n_tests += 3;
      if (req_log[i] !== e) begin n_fail++; $display("FAIL seq_req%0d: got %h want %h", i, req_log[i], e); end
      if (opc_log[i] !== e) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, opc_log[i], e); end
      if (oins_log[i] !== f(e)) begin n_fail++; $display("FAIL seq_instr%0d: got %h want %h", i, oins_log[i], f(e)); end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    do_reset(1'b0, '0);
    repeat (20) tick();
    n_tests += 3;
    if (req_n !== 2) begin n_fail++; $display("FAIL bp_req_count: got %0d want 2", req_n); end
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    if (out_pc !== RPC) begin n_fail++; $display("FAIL bp_head_pc: got %h want %h", out_pc, RPC); end
    out_ready = 1'b1;
    wait_out(4, 100);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] e;
      e = RPC + 64'(4 * i);
      n_tests++;
      if (opc_log[i] !== e) begin n_fail++; $display("FAIL bp_pc%0d: got %h want %h", i, opc_log[i], e); end
    end
    n_tests++;
    if (req_log[2] !== RPC + 64'h8) begin n_fail++; $display("FAIL bp_resume_addr: got %h want %h", req_log[2], RPC + 64'h8); end
  endtask

  task automatic test_redirect_wait();
    int k = 0;
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b0;
    do_reset(1'b0, '0);
    while (req_n < 2 && k < 100) begin tick(); k++; end
    n_tests += 2;
    if (req_n !== 2) begin n_fail++; $display("FAIL rw_second_req: got %0d reqs want 2", req_n); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rw_buffered: got %b want 1", out_valid); end
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush: got %b want 0", out_valid); end
    out_ready = 1'b1;
    wait_out(2, 100);
    n_tests += 4;
    if (opc_log[0] !== 64'h2000) begin n_fail++; $display("FAIL rw_pc0: got %h want 2000", opc_log[0]); end
    if (oins_log[0] !== f(64'h2000)) begin n_fail++; $display("FAIL rw_instr0: got %h want %h", oins_log[0], f(64'h2000)); end
    if (opc_log[1] !== 64'h2004) begin n_fail++; $display("FAIL rw_pc1: got %h want 2004", opc_log[1]); end
    if (req_log[2] !== 64'h2000) begin n_fail++; $display("FAIL rw_req2: got %h want 2000", req_log[2]); end
  endtask

  task automatic test_redirect_coincident();
    int k = 0;
    int prev, mark, mark_r;
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    do_reset(1'b0, '0);
    while (imem_req_valid !== 1'b1 && k < 50) begin tick(); k++; end
    // Redirect lands on the same edge as the request handshake.
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    wait_out(2, 100);
    n_tests += 4;
    if (req_log[0] !== RPC) begin n_fail++; $display("FAIL hs_req0: got %h want %h", req_log[0], RPC); end
    if (req_log[1] !== 64'h3000) begin n_fail++; $display("FAIL hs_req1: got %h want 3000", req_log[1]); end
    if (opc_log[0] !== 64'h3000) begin n_fail++; $display("FAIL hs_pc0: got %h want 3000", opc_log[0]); end
    if (oins_log[0] !== f(64'h3000)) begin n_fail++; $display("FAIL hs_instr0: got %h want %h", oins_log[0], f(64'h3000)); end
    // Redirect lands on the same edge as the response.
    prev = req_n; k = 0;
    while (req_n == prev && k < 50) begin tick(); k++; end
    mark = out_n;
    redirect_valid = 1'b1; redirect_pc = 64'h4000;
    tick();
    redirect_valid = 1'b0;
    mark_r = req_n;
    wait_out(mark + 2, 100);
    n_tests += 3;
    if (opc_log[mark] !== 64'h4000) begin n_fail++; $display("FAIL rsp_pc0: got %h want 4000", opc_log[mark]); end
    if (opc_log[mark+1] !== 64'h4004) begin n_fail++; $display("FAIL rsp_pc1: got %h want 4004", opc_log[mark+1]); end
    if (req_log[mark_r] !== 64'h4000) begin n_fail++; $display("FAIL rsp_req: got %h want 4000", req_log[mark_r]); end
  endtask

  task automatic test_wrap();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    do_reset(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    n_tests++;
    if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr_load: got %h want fffffffffffffffc", imem_req_addr); end
    wait_out(2, 100);
    n_tests += 4;
    if (req_log[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_req1: got %h want 0", req_log[1]); end
    if (opc_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: got %h want fffffffffffffffc", opc_log[0]); end
    if (opc_log[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_pc1: got %h want 0", opc_log[1]); end
    if (oins_log[1] !== f(64'h0)) begin n_fail++; $display("FAIL wrap_instr1: got %h want %h", oins_log[1], f(64'h0)); end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    int mark;
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    do_reset(1'b1, 64'h2002);
    repeat (10) tick();
    n_tests += 6;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL al_valid: got %b want 1", out_valid); end
    if (out_fault !== 1'b1) begin n_fail++; $display("FAIL al_fault: got %b want 1", out_fault); end
    if (out_pc !== 64'h2002) begin n_fail++; $display("FAIL al_pc: got %h want 2002", out_pc); end
    if (out_instr !== 32'h0) begin n_fail++; $display("FAIL al_instr: got %h want 0", out_instr); end
    if (req_n !== 0) begin n_fail++; $display("FAIL al_no_req: got %0d reqs want 0", req_n); end
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL al_req_valid: got %b want 0", imem_req_valid); end
    out_ready = 1'b1;
    tick();
    repeat (5) tick();
    n_tests += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL al_single: got %b want 0", out_valid); end
    if (req_n !== 0) begin n_fail++; $display("FAIL al_halted: got %0d reqs want 0", req_n); end
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    mark = out_n;
    wait_out(mark + 2, 100);
    n_tests += 3;
    if (req_log[0] !== 64'h3000) begin n_fail++; $display("FAIL al_resume_req: got %h want 3000", req_log[0]); end
    if (opc_log[mark] !== 64'h3000) begin n_fail++; $display("FAIL al_resume_pc: got %h want 3000", opc_log[mark]); end
    if (oflt_log[mark] !== 1'b0) begin n_fail++; $display("FAIL al_resume_fault: got %b want 0", oflt_log[mark]); end
  endtask
`else
  task automatic test_align();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    do_reset(1'b1, 64'h2002);
    wait_out(1, 100);
    n_tests += 3;
    if (req_log[0] !== 64'h2000) begin n_fail++; $display("FAIL fa_req: got %h want 2000", req_log[0]); end
    if (opc_log[0] !== 64'h2000) begin n_fail++; $display("FAIL fa_pc: got %h want 2000", opc_log[0]); end
    if (oflt_log[0] !== 1'b0) begin n_fail++; $display("FAIL fa_fault: got %b want 0", oflt_log[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_align();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the next-PC logic.
- Owns the architectural fetch PC and issues one-outstanding requests to instruction memory.
- Buffers returned instructions with their PCs in a small queue for decode.
- Accepts redirect targets computed by the branch/next-PC logic. Supplies CurrentPC for each decoded instruction.

Parameters:
- RESET_PC, 64'h0: fetch PC loaded on reset.
- QDEPTH, 2: instruction queue entries; legal values 2 or 4.

Ports:
- CLK  in  1  single clock, rising edge.
- resetl  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  branch/jump resolved taken; load redirect_pc.
- redirect_pc  in  64  new fetch target (NextPC of taken branch).
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address.
- imem_rsp_valid  in  1  instruction returned (exactly one per accepted request, ≥1 cycle later).
- imem_rsp_data  in  32  instruction word.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode consumes head.
- out_pc  out  64  CurrentPC of head instruction.
- out_instr  out  32  head instruction.
- out_fault  out  1  head is misaligned-fetch fault (feature only, else 0).

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC; state=IDLE; queue empty; drop=0.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - out_valid=0, out_pc=0, out_instr=0, out_fault=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ when count < QDEPTH (one slot is reserved for the outstanding response).
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc. On imem_req_ready: capture req_pc=fetch_pc, fetch_pc+=4 (mod 2^64, wraps silently), → WAIT.
  - WAIT: on imem_rsp_valid:
    - if drop=0, push {req_pc, rsp_data}; if drop=1, discard and clear drop.
    - then → REQ if the slot-reservation condition still holds (count after this cycle's push/pop < QDEPTH), else → IDLE.
- Throughput: one request per 2 cycles minimum with 1-cycle memory; no more than one request in flight.
- Queue:
  - out_valid = count≠0; out_pc/out_instr = head entry, zero when empty.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle are legal; count unchanged.
  - Overflow is impossible by reservation. Verify with an assertion.
- Redirect (highest priority):
  - In the redirect cycle: queue flushed (out_valid=0 next cycle), fetch_pc<=redirect_pc, any concurrent pop or push is ignored.
  - From IDLE/REQ without handshake → IDLE; the next request uses the new address. imem_req_valid may drop; instruction memory tolerates request withdrawal.
  - From WAIT, or from REQ with handshake in the same cycle → WAIT with drop=1; the stale response is discarded.
  - If in WAIT and rsp_valid coincides with redirect, that response is discarded and drop stays 0.
- Back-to-back redirects: the last one wins; drop remains a single bit (only one outstanding).
- Reset mid-operation: all state is cleared immediately. A memory response after reset is not expected; the system resets memory together with this block.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- With the macro defined:
  - A redirect_pc with bits[1:0]≠0 loads fetch_pc but issues no request.
  - A single fault entry {pc, 32'h0, fault=1} is pushed into the queue.
  - FSM enters a HALT state until the next redirect.
- Without the macro:
  - redirect_pc[1:0] are forced to 0.
  - out_fault is tied 0 and there is no HALT state.

Decomposition:
- Package fetch_pkg:
  - constants PC_W=64, INSTR_W=32, PC_INC=64'd4.
  - fetch_state_t enum {IDLE, REQ, WAIT, HALT}.
  - fetch_entry_t struct {pc, instr, fault}.
- Sub-module fetch_queue: parameterised QDEPTH FIFO of fetch_entry_t with synchronous flush, count output, push/pop.

Test Plan:
- Reset with RESET_PC=64'h1000, memory ready/1-cycle latency, out_ready=1 → requests 0x1000, 0x1004, 0x1008; out_pc follows in order with matching instructions.
- out_ready=0 with QDEPTH=2 → exactly 2 entries buffered, imem_req_valid stays 0. Release → resumes at the next sequential PC, no loss or duplication.
- Redirect to 0x2000 while in WAIT (memory latency 3) → stale response for old PC dropped, next out_pc=0x2000, queue was flushed.
- Redirect coincident with req handshake and with rsp_valid → neither old instruction reaches decode; first output is the redirect target.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC sequential → next request address 0x0.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x2002 → one entry out_fault=1, out_pc=0x2002, no imem request until redirect to 0x3000, then normal fetch resumes.
